sprite_line_scheduler: RTL

- Per-scanline scheduler in front of the shared sprite drawing engine.
- On each line-start strobe from the VGA timing block, scans a table of NSPR sprite slots and finds sprites whose vertical span covers the current line.
- Issues them to the engine one at a time, in slot-index order, over a valid/ready request and done-pulse handshake.
- Flags per-line overflow and late-line overrun.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_slot_table.sv | 43 ++++
 rtl/sprite_line_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite line scheduler.
//   state_t : scheduler FSM states
//   slot_t  : one sprite slot {en, x, y, h}
//   SPR_CW / SPR_NSPR : default coordinate width and slot count
package sprite_pkg;
  localparam int SPR_CW   = 10;
  localparam int SPR_NSPR = 8;

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic              en;
    logic [SPR_CW-1:0] x;
    logic [SPR_CW-1:0] y;
    logic [SPR_CW-1:0] h;
  } slot_t;
endpackage

// File: rtl/sprite_slot_table.sv
// Sprite slot register file with one write port and one combinational
// read port that evaluates the vertical hit test for a given line.
//   clk, rst_n     : clock, synchronous active-low reset (clears all slots)
//   we, widx, wslot: slot write
//   ridx, line     : slot to test and line number to test against
//   hit, x, row    : hit flag, slot x, row within sprite (line - y)
module sprite_slot_table
  import sprite_pkg::*;
#(
  parameter int NSPR = SPR_NSPR,
  parameter int CW   = SPR_CW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(NSPR)-1:0] widx,
  input  slot_t                   wslot,
  input  logic [$clog2(NSPR)-1:0] ridx,
  input  logic [CW-1:0]           line,
  output logic                    hit,
  output logic [CW-1:0]           x,
  output logic [CW-1:0]           row
);
  slot_t slots [NSPR];
  slot_t cur;
  logic [CW:0] bottom;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSPR; i++) slots[i] <= '0;
    end else if (we) begin
      slots[widx] <= wslot;
    end
  end

  assign cur    = slots[ridx];
  // One extra bit so a sprite near the bottom of the coordinate range
  // cannot wrap around and hit small line numbers. h=0 gives an empty span.
  assign bottom = {1'b0, cur.y} + {1'b0, cur.h};
  assign hit    = cur.en && (line >= cur.y) && ({1'b0, line} < bottom);
  assign x      = cur.x;
  assign row    = line - cur.y;
endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler. On line_start it scans all slots in index
// order and issues covering sprites to the draw engine one at a time.
//   line_start/sy        : line strobe and line number
//   cfg_*                : slot table write port
//   req_valid/ready/id/x/row : request to engine; eng_done ends a request
//   busy                 : not idle
//   line_overflow        : one-cycle pulse per hit dropped over MAX_PER_LINE
//   overrun/overrun_clr  : sticky flag for line_start while busy, and clear
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NSPR         = SPR_NSPR,
  parameter int MAX_PER_LINE = 4,
  parameter int CW           = SPR_CW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_start,
  input  logic [CW-1:0]           sy,
  input  logic                    cfg_we,
  input  logic [$clog2(NSPR)-1:0] cfg_idx,
  input  logic                    cfg_en,
  input  logic [CW-1:0]           cfg_x,
  input  logic [CW-1:0]           cfg_y,
  input  logic [CW-1:0]           cfg_h,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [$clog2(NSPR)-1:0] req_id,
  output logic [CW-1:0]           req_x,
  output logic [CW-1:0]           req_row,
  input  logic                    eng_done,
  output logic                    busy,
  output logic                    line_overflow,
  output logic                    overrun,
  input  logic                    overrun_clr
);
  localparam int IW   = $clog2(NSPR);
  localparam int CNTW = $clog2(MAX_PER_LINE + 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [CW-1:0]   sy_lat, sy_nxt;
  logic            capture, ovf_nxt, ovr_nxt, last;
  logic            hit;
  logic [CW-1:0]   hit_x, hit_row;
  slot_t           wslot;

  assign wslot = '{en: cfg_en, x: cfg_x, y: cfg_y, h: cfg_h};

  sprite_slot_table #(.NSPR(NSPR), .CW(CW)) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .widx  (cfg_idx),
    .wslot (wslot),
    .ridx  (idx),
    .line  (sy_lat),
    .hit   (hit),
    .x     (hit_x),
    .row   (hit_row)
  );

  assign last = (idx == IW'(NSPR - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    sy_nxt    = sy_lat;
    capture   = 1'b0;
    ovf_nxt   = 1'b0;
    ovr_nxt   = overrun_clr ? 1'b0 : overrun;
    if (line_start) begin
      // A new line always restarts the scan; arriving mid-line aborts the
      // current one and any outstanding engine done is simply not waited for.
      if (state != IDLE) ovr_nxt = 1'b1;
      state_nxt = SCAN;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      sy_nxt    = sy;
    end else begin
      case (state)
        SCAN: begin
          if (hit && (cnt < CNTW'(MAX_PER_LINE))) begin
            capture   = 1'b1;
            state_nxt = ISSUE;
          end else begin
            ovf_nxt = hit;
            if (last) state_nxt = IDLE;
            else      idx_nxt   = idx + 1'b1;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            state_nxt = WAIT;
            cnt_nxt   = cnt + 1'b1;
          end
        end
        WAIT: begin
          if (eng_done) begin
            if (last) state_nxt = IDLE;
            else begin
              state_nxt = SCAN;
              idx_nxt   = idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      sy_lat        <= '0;
      req_id        <= '0;
      req_x         <= '0;
      req_row       <= '0;
      line_overflow <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      sy_lat        <= sy_nxt;
      line_overflow <= ovf_nxt;
      overrun       <= ovr_nxt;
      // Request fields are snapshotted so later cfg writes cannot disturb them.
      if (capture) begin
        req_id  <= idx;
        req_x   <= hit_x;
        req_row <= hit_row;
      end
    end
  end

  assign req_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
endmodule
